alu_op_issuer: RTL
==================

Name: alu_op_issuer

Overview:
- Sending end of the ALU action interface: accepts one PHV plus one 25-bit action word per request and decodes the opcode and operand selectors.
- Issues action/operand pairs to an alu_1 instance, captures container_out, writes the result back into the PHV and presents the updated PHV downstream.
- Sits between the stage's action-table lookup and the PHV output register of each RMT stage.

Parameters:
- STAGE_ID, 0, stage index; informational, carried into stats.
- ACTION_LEN, 25, action word width.
- DATA_WIDTH, 48, container width.
- NUM_CONTAINERS, 16, PHV containers; PHV width = NUM_CONTAINERS*DATA_WIDTH.
- TIMEOUT, 8, max cycles in WAIT before abandoning the ALU result (≥2).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- phv_in  in  NUM_CONTAINERS*DATA_WIDTH  request PHV; container i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- action_word_in  in  ACTION_LEN  request action.
- req_valid_in  in  1  request valid.
- req_ready_out  out  1  accepts request when high.
- action_out  out  ACTION_LEN  to alu_1 action_in.
- action_valid_out  out  1  to alu_1 action_valid.
- operand_1_out  out  DATA_WIDTH  to alu_1 operand_1_in.
- operand_2_out  out  DATA_WIDTH  to alu_1 operand_2_in.
- container_in  in  DATA_WIDTH  from alu_1 container_out.
- container_in_valid  in  1  from alu_1 container_out_valid.
- phv_out  out  NUM_CONTAINERS*DATA_WIDTH  updated PHV.
- phv_out_valid  out  1  phv_out valid.
- phv_out_ready  in  1  downstream accept.
- err_illegal  out  1  one-cycle pulse: illegal action.
- err_timeout  out  1  one-cycle pulse: ALU result not seen.

Behaviour:
- Action format:
  - [24:21] opcode.
  - [20:10] 11-bit immediate.
  - [9:5] op1/destination index.
  - [4:0] op2 index.
- Opcodes:
  - 0001 ADD and 0010 SUB: operand_2 = container[op2].
  - 1001 ADDI and 1010 SUBI: operand_2 = zero-extended immediate.
  - Any other opcode is illegal.
  - Any op1 index ≥ NUM_CONTAINERS is illegal.
  - For ADD/SUB, any op2 index ≥ NUM_CONTAINERS is illegal.
- ALU-side opcode mapping: ADDI is sent to the ALU as opcode 0001 and SUBI as 0010. Bits [20:0] are forwarded unchanged.
- Reset values: all outputs 0 except req_ready_out = 1. State = IDLE; latched PHV/action = 0.
- FSM:
  - IDLE: req_ready_out = 1. On req_valid_in & req_ready_out, latch phv_in and action_word_in. Go to ISSUE if legal, else REJECT.
  - REJECT: err_illegal = 1 for this cycle only; phv_out = latched PHV, unchanged; go to OUT.
  - ISSUE: action_valid_out = 1 for exactly one cycle with operands taken from the latched PHV. Clear the wait counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - If container_in_valid: write container_in into latched container[op1], go to OUT. A valid result has priority over a timeout in the same cycle.
    - Else if counter == TIMEOUT-1: err_timeout pulse, PHV unchanged, go to OUT.
  - OUT: phv_out_valid = 1, held until phv_out_ready. phv_out stays stable while valid & !ready. On handshake go to IDLE.
- req_ready_out is 0 in every state except IDLE. There is no overlap; at most one request is in flight.
- container_in_valid outside WAIT is ignored and the PHV is not modified.
- action_out, operand_1_out and operand_2_out return to 0 when action_valid_out is low.
- Latency with alu_1's 1-cycle latency and phv_out_ready = 1:
  - request accept (cycle 0) → ISSUE (cycle 1) → result (cycle 2) → phv_out_valid (cycle 3).
  - Illegal request: phv_out_valid at cycle 2.
- rst asserted in any state forces IDLE immediately. Any in-flight request is dropped with no output; a later ALU result is ignored.

Optional Feature:
- Macro ALU_ISSUER_STATS_EN.
- Defined:
  - Adds outputs stat_issued, stat_illegal and stat_timeout, each 32 bits, cleared by rst.
  - stat_issued increments on each ISSUE cycle; stat_illegal on each err_illegal pulse; stat_timeout on each err_timeout pulse.
  - Counters saturate at all-ones.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rmt_action_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_ADDI, OP_SUBI;
  - field offsets and widths (OPC_MSB, IMM_LSB, OP1_LSB, OP2_LSB, IDX_W, IMM_W);
  - FSM state encoding.
- Sub-module alu_action_decode: combinational; maps the action word to legal flag, ALU opcode, op1/op2 indices, immediate-select and immediate value.
- The top level holds the FSM, PHV latch, operand muxing and counters.

Test Plan:
1. ADD: action {0001, 21'b0010001001} (op1=4, op2=9), container4=1, container9=3 → one-cycle action_valid_out with operand_1=1, operand_2=3 and ALU action 0001; ALU returns 4; phv_out container4=4, all others unchanged, phv_out_valid at cycle 3.
2. SUBI: opcode 1010, imm=3, op1=4 with container4=20 → action_out opcode 0010, operand_2_out=3; ALU returns 17; phv_out container4=17.
3. Illegal: opcode 0011 → no action_valid_out; err_illegal pulse at cycle 1; phv_out equals phv_in at cycle 2.
4. Timeout: legal ADD, ALU result never returned → err_timeout after TIMEOUT=8 WAIT cycles; PHV unchanged; a late container_in_valid has no effect.
5. Backpressure: phv_out_ready low for 5 cycles → phv_out stable, req_ready_out low throughout; a request offered meanwhile is accepted only after the handshake.
6. Reset mid-WAIT: assert rst → all outputs at reset values immediately; an ALU result after rst release is ignored; the next request completes normally.

Source files
------------

// File: rtl/rmt_action_pkg.sv
// Shared definitions for the RMT stage action path: action-word field layout,
// opcode constants and the issuer FSM state encoding.
package rmt_action_pkg;

    // Action word layout: [24:21] opcode, [20:10] immediate, [9:5] op1/dest, [4:0] op2
    localparam int OPC_MSB = 24;
    localparam int OPC_W   = 4;
    localparam int IMM_LSB = 10;
    localparam int IMM_W   = 11;
    localparam int OP1_LSB = 5;
    localparam int OP2_LSB = 0;
    localparam int IDX_W   = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'b1001;
    localparam logic [OPC_W-1:0] OP_SUBI = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REJECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } issuer_state_e;

endpackage

// File: rtl/alu_action_decode.sv
// Combinational action-word decoder: legality, ALU-side opcode, operand
// indices and immediate selection. Immediate forms are mapped onto the
// register forms the ALU understands (ADDI->ADD, SUBI->SUB).
module alu_action_decode
    import rmt_action_pkg::*;
#(
    parameter int ACTION_LEN     = 25,
    parameter int NUM_CONTAINERS = 16
) (
    input  logic [ACTION_LEN-1:0] action_word,
    output logic                  legal,
    output logic [OPC_W-1:0]      alu_opcode,
    output logic [IDX_W-1:0]      op1_idx,
    output logic [IDX_W-1:0]      op2_idx,
    output logic                  imm_sel,
    output logic [IMM_W-1:0]      imm
);

    logic [OPC_W-1:0] opcode;
    logic             op1_ok;
    logic             op2_ok;

    assign opcode  = action_word[OPC_MSB -: OPC_W];
    assign op1_idx = action_word[OP1_LSB +: IDX_W];
    assign op2_idx = action_word[OP2_LSB +: IDX_W];
    assign imm     = action_word[IMM_LSB +: IMM_W];
    assign op1_ok  = int'(op1_idx) < NUM_CONTAINERS;
    assign op2_ok  = int'(op2_idx) < NUM_CONTAINERS;

    // Opcode classification; op2 range only matters for register forms
    always_comb begin
        legal      = 1'b0;
        alu_opcode = opcode;
        imm_sel    = 1'b0;
        case (opcode)
            OP_ADD: begin
                legal      = op1_ok && op2_ok;
                alu_opcode = OP_ADD;
            end
            OP_SUB: begin
                legal      = op1_ok && op2_ok;
                alu_opcode = OP_SUB;
            end
            OP_ADDI: begin
                legal      = op1_ok;
                alu_opcode = OP_ADD;
                imm_sel    = 1'b1;
            end
            OP_SUBI: begin
                legal      = op1_ok;
                alu_opcode = OP_SUB;
                imm_sel    = 1'b1;
            end
            default: begin
                legal      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// ALU action issuer for one RMT stage: accepts a PHV + action word, issues a
// single operand pair to alu_1, writes the returned container back into the
// PHV and presents the updated PHV downstream.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; a valid, once raised, holds its payload stable until that
// edge. Only one request is in flight, so req_ready_out is high only in IDLE.
//
// Optional build macro: ALU_ISSUER_STATS_EN adds saturating 32-bit counters
// stat_issued, stat_illegal and stat_timeout.
module alu_op_issuer
    import rmt_action_pkg::*;
#(
    parameter int STAGE_ID       = 0,
    parameter int ACTION_LEN     = 25,
    parameter int DATA_WIDTH     = 48,
    parameter int NUM_CONTAINERS = 16,
    parameter int TIMEOUT        = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_in,
    input  logic [ACTION_LEN-1:0]              action_word_in,
    input  logic                               req_valid_in,
    output logic                               req_ready_out,
    output logic [ACTION_LEN-1:0]              action_out,
    output logic                               action_valid_out,
    output logic [DATA_WIDTH-1:0]              operand_1_out,
    output logic [DATA_WIDTH-1:0]              operand_2_out,
    input  logic [DATA_WIDTH-1:0]              container_in,
    input  logic                               container_in_valid,
    output logic [NUM_CONTAINERS*DATA_WIDTH-1:0] phv_out,
    output logic                               phv_out_valid,
    input  logic                               phv_out_ready,
    output logic                               err_illegal,
    output logic                               err_timeout
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [31:0]                        stat_issued,
    output logic [31:0]                        stat_illegal,
    output logic [31:0]                        stat_timeout
`endif
);

    localparam int PHV_W = NUM_CONTAINERS * DATA_WIDTH;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int FWD_W = ACTION_LEN - OPC_W;

    // Decoded view of the incoming action word
    logic             dec_legal;
    logic [OPC_W-1:0] dec_alu_opc;
    logic [IDX_W-1:0] dec_op1_idx;
    logic [IDX_W-1:0] dec_op2_idx;
    logic             dec_imm_sel;
    logic [IMM_W-1:0] dec_imm;

    alu_action_decode #(
        .ACTION_LEN     (ACTION_LEN),
        .NUM_CONTAINERS (NUM_CONTAINERS)
    ) u_decode (
        .action_word (action_word_in),
        .legal       (dec_legal),
        .alu_opcode  (dec_alu_opc),
        .op1_idx     (dec_op1_idx),
        .op2_idx     (dec_op2_idx),
        .imm_sel     (dec_imm_sel),
        .imm         (dec_imm)
    );

    // Only the destination index of the latched action is needed after issue
    issuer_state_e         state_q, state_d;
    logic [PHV_W-1:0]      phv_q, phv_d;
    logic [IDX_W-1:0]      op1_idx_q, op1_idx_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  action_valid_q, action_valid_d;
    logic [ACTION_LEN-1:0] action_out_q, action_out_d;
    logic [DATA_WIDTH-1:0] operand_1_q, operand_1_d;
    logic [DATA_WIDTH-1:0] operand_2_q, operand_2_d;
    logic [PHV_W-1:0]      phv_out_q, phv_out_d;
    logic                  phv_out_valid_q, phv_out_valid_d;
    logic                  err_illegal_q, err_illegal_d;
    logic                  err_timeout_q, err_timeout_d;

    // Selects one container by index; out-of-range indices read as zero
    function automatic logic [DATA_WIDTH-1:0] container_sel(
        input logic [PHV_W-1:0] phv,
        input logic [IDX_W-1:0] idx
    );
        container_sel = '0;
        for (int i = 0; i < NUM_CONTAINERS; i++) begin
            if (int'(idx) == i) container_sel = phv[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endfunction

    // Next-state and registered-output computation for the issue FSM
    always_comb begin
        state_d         = state_q;
        phv_d           = phv_q;
        op1_idx_d       = op1_idx_q;
        wait_cnt_d      = wait_cnt_q;
        action_valid_d  = 1'b0;
        action_out_d    = '0;
        operand_1_d     = '0;
        operand_2_d     = '0;
        phv_out_d       = phv_out_q;
        phv_out_valid_d = phv_out_valid_q;
        err_illegal_d   = 1'b0;
        err_timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_in) begin
                    phv_d     = phv_in;
                    op1_idx_d = dec_op1_idx;
                    if (dec_legal) begin
                        // Operands come from the PHV being latched on this edge
                        state_d        = ST_ISSUE;
                        action_valid_d = 1'b1;
                        action_out_d   = {dec_alu_opc, action_word_in[FWD_W-1:0]};
                        operand_1_d    = container_sel(phv_in, dec_op1_idx);
                        operand_2_d    = dec_imm_sel ? DATA_WIDTH'(dec_imm)
                                                     : container_sel(phv_in, dec_op2_idx);
                    end else begin
                        state_d       = ST_REJECT;
                        err_illegal_d = 1'b1;
                    end
                end
            end
            ST_REJECT: begin
                state_d         = ST_OUT;
                phv_out_d       = phv_q;
                phv_out_valid_d = 1'b1;
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (container_in_valid) begin
                    // A result arriving on the last wait cycle still wins
                    for (int i = 0; i < NUM_CONTAINERS; i++) begin
                        if (int'(op1_idx_q) == i) phv_d[i*DATA_WIDTH +: DATA_WIDTH] = container_in;
                    end
                    phv_out_d       = phv_d;
                    phv_out_valid_d = 1'b1;
                    state_d         = ST_OUT;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_timeout_d   = 1'b1;
                    phv_out_d       = phv_q;
                    phv_out_valid_d = 1'b1;
                    state_d         = ST_OUT;
                end
            end
            ST_OUT: begin
                if (phv_out_ready) begin
                    phv_out_valid_d = 1'b0;
                    phv_out_d       = '0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            phv_q           <= '0;
            op1_idx_q       <= '0;
            wait_cnt_q      <= '0;
            action_valid_q  <= 1'b0;
            action_out_q    <= '0;
            operand_1_q     <= '0;
            operand_2_q     <= '0;
            phv_out_q       <= '0;
            phv_out_valid_q <= 1'b0;
            err_illegal_q   <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            phv_q           <= phv_d;
            op1_idx_q       <= op1_idx_d;
            wait_cnt_q      <= wait_cnt_d;
            action_valid_q  <= action_valid_d;
            action_out_q    <= action_out_d;
            operand_1_q     <= operand_1_d;
            operand_2_q     <= operand_2_d;
            phv_out_q       <= phv_out_d;
            phv_out_valid_q <= phv_out_valid_d;
            err_illegal_q   <= err_illegal_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign req_ready_out    = (state_q == ST_IDLE);
    assign action_valid_out = action_valid_q;
    assign action_out       = action_out_q;
    assign operand_1_out    = operand_1_q;
    assign operand_2_out    = operand_2_q;
    assign phv_out          = phv_out_q;
    assign phv_out_valid    = phv_out_valid_q;
    assign err_illegal      = err_illegal_q;
    assign err_timeout      = err_timeout_q;

`ifdef ALU_ISSUER_STATS_EN
    // Stage index is informational only and travels with the stats build
    localparam logic [31:0] STAT_STAGE = 32'(STAGE_ID);

    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_illegal_q, stat_illegal_d;
    logic [31:0] stat_timeout_q, stat_timeout_d;

    // Saturating event counters
    always_comb begin
        stat_issued_d  = stat_issued_q;
        stat_illegal_d = stat_illegal_q;
        stat_timeout_d = stat_timeout_q;
        if (state_q == ST_ISSUE && stat_issued_q != '1) stat_issued_d = stat_issued_q + 32'd1;
        if (err_illegal_q && stat_illegal_q != '1)      stat_illegal_d = stat_illegal_q + 32'd1;
        if (err_timeout_q && stat_timeout_q != '1)      stat_timeout_d = stat_timeout_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q  <= '0;
            stat_illegal_q <= '0;
            stat_timeout_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_illegal_q <= stat_illegal_d;
            stat_timeout_q <= stat_timeout_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_illegal = stat_illegal_q;
    assign stat_timeout = stat_timeout_q;
`else
    localparam int STAT_STAGE = STAGE_ID;
`endif

endmodule
